// File: rtl/pipe_stage_skid_reg.sv
// rtl/pipe_stage_skid_reg.sv - valid/ready pipeline stage register with 2-entry skid buffer
// Optional stall/flush counters are built when PIPE_STAGE_PERF_CNT_EN is defined.
module pipe_stage_skid_reg #(
  parameter int CTRL_W = 10,
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // State bits are {m_v, s_v}.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic [CTRL_W-1:0]   m_ctrl_q, m_ctrl_d, s_ctrl_q, s_ctrl_d;
  logic [DATA_W-1:0]   m_data_q, m_data_d, s_data_q, s_data_d;

  logic m_v, s_v, accept, pop;

  assign m_v    = state_q[1];
  assign s_v    = state_q[0];
  assign accept = in_valid & in_ready_q & ~flush;
  assign pop    = m_v & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      m_ctrl_q   <= '0;
      s_ctrl_q   <= '0;
      m_data_q   <= '0;
      s_data_q   <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      m_ctrl_q   <= m_ctrl_d;
      s_ctrl_q   <= s_ctrl_d;
      m_data_q   <= m_data_d;
      s_data_q   <= s_data_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    m_ctrl_d = m_ctrl_q;
    s_ctrl_d = s_ctrl_q;
    m_data_d = m_data_q;
    s_data_d = s_data_q;
    if (flush) begin
      // Payload is kept; only control is killed so bubbles cannot write back.
      state_d  = EMPTY;
      m_ctrl_d = '0;
      s_ctrl_d = '0;
    end else begin
      unique case (state_q)
        ONE: begin
          if (accept && pop) begin
            m_ctrl_d = in_ctrl;
            m_data_d = in_data;
          end else if (accept) begin
            state_d  = FULL;
            s_ctrl_d = in_ctrl;
            s_data_d = in_data;
          end else if (pop) begin
            state_d  = EMPTY;
            m_ctrl_d = '0;
          end
        end
        FULL: begin
          if (pop) begin
            state_d  = ONE;
            m_ctrl_d = s_ctrl_q;
            m_data_d = s_data_q;
            s_ctrl_d = '0;
          end
        end
        default: begin
          if (accept) begin
            state_d  = ONE;
            m_ctrl_d = in_ctrl;
            m_data_d = in_data;
          end
        end
      endcase
    end
    in_ready_d = ~state_d[0];
  end

  assign in_ready  = in_ready_q;
  assign out_valid = m_v;
  assign out_ctrl  = m_ctrl_q & {CTRL_W{m_v}};
  assign out_data  = m_data_q;

`ifdef PIPE_STAGE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (m_v && !out_ready && !flush && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush && (m_v || s_v) && (flush_cnt_q != {CNT_W{1'b1}}))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// tb/tb_pipe_stage_skid_reg.sv - directed self-checking bench for pipe_stage_skid_reg
module tb_pipe_stage_skid_reg;

  localparam int CTRL_W = 10;
  localparam int DATA_W = 128;
  localparam int CNT_W  = 16;

`ifdef PIPE_STAGE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  logic              in_ready3;
  logic              out_valid3;
  logic [CTRL_W-1:0] out_ctrl3;
  logic [DATA_W-1:0] out_data3;
  logic [2:0]        stall_cnt3;
  logic [2:0]        flush_cnt3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_skid_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Narrow-counter instance for saturation.
  pipe_stage_skid_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(3)) dut3 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready3), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid3), .out_ready(out_ready), .out_ctrl(out_ctrl3), .out_data(out_data3),
    .stall_cnt(stall_cnt3), .flush_cnt(flush_cnt3)
  );

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0, '0);
    step(); step();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_ctrl", out_ctrl, 0);
    check("rst_out_data", out_data, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_flush_cnt", flush_cnt, 0);
    reset = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);

    // Streaming at full rate.
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, CTRL_W'(i), DATA_W'(i));
      step();
      check("stream_valid", out_valid, 1);
      check("stream_ctrl", out_ctrl, DATA_W'(i));
      check("stream_data", out_data, DATA_W'(i));
      check("stream_in_ready", in_ready, 1);
    end
    in_valid = 1'b0; in_ctrl = 'x; in_data = 'x;
    step();
    check("drain_valid", out_valid, 0);
    check("drain_ctrl_zero", out_ctrl, 0);
    check("drain_data_kept", out_data, 5);

    // Backpressure fill.
    out_ready = 1'b0;
    drive(1'b1, 10'h3FF, 128'hAA);
    step();
    check("bp_a_ctrl", out_ctrl, 10'h3FF);
    check("bp_a_in_ready", in_ready, 1);
    drive(1'b1, 10'h0BB, 128'hBB);
    step();
    check("bp_full_in_ready", in_ready, 0);
    check("bp_full_ctrl", out_ctrl, 10'h3FF);
    drive(1'b1, 10'h0CC, 128'hCC);
    step();
    check("bp_c_blocked_ready", in_ready, 0);
    check("bp_hold_ctrl", out_ctrl, 10'h3FF);
    check("bp_hold_data", out_data, 128'hAA);
    out_ready = 1'b1;
    step();
    check("bp_b_ctrl", out_ctrl, 10'h0BB);
    check("bp_b_data", out_data, 128'hBB);
    check("bp_b_in_ready", in_ready, 1);
    step();
    check("bp_c_ctrl", out_ctrl, 10'h0CC);
    check("bp_c_data", out_data, 128'hCC);
    drive(1'b0, '0, '0);
    step();
    check("bp_empty", out_valid, 0);

    // Flush while FULL with an incoming entry.
    out_ready = 1'b0;
    drive(1'b1, 10'h011, 128'hD1); step();
    drive(1'b1, 10'h022, 128'hE2); step();
    check("fl_full", in_ready, 0);
    drive(1'b1, 10'h033, 128'hF3);
    flush = 1'b1;
    step();
    check("fl_valid", out_valid, 0);
    check("fl_ctrl", out_ctrl, 0);
    check("fl_data_kept", out_data, 128'hD1);
    check("fl_in_ready", in_ready, 1);
    check("fl_flush_cnt", flush_cnt, PERF ? 1 : 0);
    flush = 1'b0;
    drive(1'b0, '0, '0);
    step();
    check("fl_dropped", out_valid, 0);

    // Flush with empty stage.
    drive(1'b1, 10'h044, 128'h44);
    flush = 1'b1;
    step();
    check("fle_valid", out_valid, 0);
    check("fle_ctrl", out_ctrl, 0);
    check("fle_flush_cnt", flush_cnt, PERF ? 1 : 0);
    flush = 1'b0;
    drive(1'b0, '0, '0);

    // Asynchronous reset mid-cycle while FULL.
    drive(1'b1, 10'h055, 128'h55); step();
    drive(1'b1, 10'h056, 128'h56); step();
    check("ar_full", in_ready, 0);
    drive(1'b0, '0, '0);
    #2 reset = 1'b1;
    #1;
    check("ar_valid", out_valid, 0);
    check("ar_data", out_data, 0);
    check("ar_ctrl", out_ctrl, 0);
    check("ar_flush_cnt", flush_cnt, 0);
    #1 reset = 1'b0;
    step();
    check("ar_in_ready", in_ready, 1);
    out_ready = 1'b1;
    drive(1'b1, 10'h066, 128'h66);
    step();
    check("ar_push_valid", out_valid, 1);
    check("ar_push_ctrl", out_ctrl, 10'h066);
    drive(1'b0, '0, '0);
    step();

    // Stall counter and saturation.
    reset = 1'b1; step(); reset = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 10'h077, 128'h77);
    step();
    drive(1'b0, '0, '0);
    for (int i = 0; i < 7; i++) step();
    check("stall_7", stall_cnt, PERF ? 7 : 0);
    check("stall3_7", stall_cnt3, PERF ? 7 : 0);
    for (int i = 0; i < 3; i++) step();
    check("stall_10", stall_cnt, PERF ? 10 : 0);
    check("stall3_sat", stall_cnt3, PERF ? 7 : 0);
    check("stall_hold_ctrl", out_ctrl, 10'h077);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
- Parametrised pipeline stage register, the successor to the fixed-field ID/EX register.
- Carries a generic control bundle and a generic data bundle between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Uses a valid/ready handshake with a 2-entry skid buffer, so in_ready is registered and there is no combinational ready path through the stage.
- A synchronous flush kills in-flight entries and zeroes their control bits; data payload is retained.

Parameters:
- CTRL_W, 10: width of the control bundle (WB/MEM/EX control bits); zeroed on flush and whenever the entry is invalid.
- DATA_W, 128: width of the data bundle (addresses, operands, immediates, register indices); never cleared except by reset.
- CNT_W, 16: width of the optional stall/flush counters.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- flush  in  1  synchronous kill of both entries and of any same-cycle input.
- in_valid  in  1  upstream presents an entry.
- in_ready  out  1  stage can accept; driven directly from a register.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- out_valid  out  1  stage holds a valid entry for downstream.
- out_ready  in  1  downstream accepts the entry this cycle.
- out_ctrl  out  CTRL_W  control bundle; all-zero whenever out_valid=0.
- out_data  out  DATA_W  data bundle of the head entry.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0 (optional feature; 0 when compiled out).
- flush_cnt  out  CNT_W  flushes that killed at least one valid entry (optional feature; 0 when compiled out).

Behaviour:
- Storage:
  - main entry (m_v, m_ctrl, m_data) drives out_*.
  - skid entry (s_v, s_ctrl, s_data).
- Handshake terms:
  - in_ready = ~s_v (registered).
  - accept = in_valid & in_ready & ~flush.
  - pop = m_v & out_ready.
- Latency: an entry accepted at edge N appears on out_* after edge N; throughput is 1 entry/cycle when out_ready is held high.
- States (encoded by m_v/s_v):
  - EMPTY (0/0): accept -> ONE, main loads the input.
  - ONE (1/0):
    - accept & pop -> ONE, main reloads.
    - accept & ~pop -> FULL, skid loads the input and main holds.
    - ~accept & pop -> EMPTY.
    - else hold.
  - FULL (1/1): in_ready=0, no accept. pop -> ONE, main <= skid, s_v<=0. Else hold.
- FIFO order is preserved; no entry is dropped or duplicated except through flush.
- Outputs must be stable while out_valid=1 and out_ready=0.
- Invalid entries store ctrl = 0, so out_ctrl = 0 whenever out_valid = 0 (bubble semantics: no regwrite/memwrite).
- Flush:
  - Next state is EMPTY: m_v=s_v=0, m_ctrl=s_ctrl=0.
  - m_data/s_data hold their previous values.
  - A same-cycle in_valid entry is dropped.
  - A same-cycle pop still counts as consumed downstream.
  - in_ready=1 on the following cycle.
- Priority: reset > flush > normal operation.
- Reset, including mid-operation or in FULL: asynchronously clears all registers, data included. The following outputs are 0:
  - out_valid, out_ctrl, out_data
  - stall_cnt, flush_cnt
- in_ready=1 while reset is deasserted from reset state.
- X on in_ctrl/in_data while in_valid=0 must not propagate to out_*.

Optional Feature:
- Macro PIPE_STAGE_PERF_CNT_EN.
- Defined:
  - stall_cnt increments each cycle with out_valid & ~out_ready & ~flush.
  - flush_cnt increments on each flush with m_v|s_v = 1.
  - Both saturate at all-ones and clear only on reset.
- Undefined: no counter flops; stall_cnt and flush_cnt are tied to 0. Ports remain present.

Test Plan:
- Reset then streaming: out_ready=1, push ctrl 0x001..0x005 with data 1..5 back-to-back -> out_valid one cycle after each accept, same order, in_ready constantly 1.
- Backpressure fill: out_ready=0, push A(ctrl 0x3FF) and B; attempt C -> B lands in skid, in_ready=0 from the next cycle, C is not accepted, out_ctrl holds 0x3FF. Then raise out_ready -> A, B, C delivered in order.
- Flush in FULL with in_valid=1: flush=1 -> next cycle out_valid=0, out_ctrl=0, out_data unchanged, in_ready=1, incoming entry dropped. flush_cnt=1 if PIPE_STAGE_PERF_CNT_EN.
- Flush with empty stage and in_valid=1 -> stays EMPTY, out_ctrl=0, flush_cnt unchanged.
- Async reset asserted mid-cycle in FULL -> immediately out_valid=0, out_data=0, in_ready=1 after release; the first push afterwards appears after 1 edge.
- Stall counter: hold out_valid=1 with out_ready=0 for 7 cycles -> stall_cnt=7 (or 0 with the macro undefined). With CNT_W=3, hold 10 cycles -> stall_cnt saturates at 7.
